fetch_stage: RTL

//  IF stage plus IF/ID pipeline register. Holds the PC and computes next-PC (sequential/branch/jump).

---
 rtl/fetch_stage_pkg.sv | 12 +
 rtl/fetch_stage_sat_counter.sv | 32 +++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned PC_INC       = 4;
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter used for the fetch stage performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Sticks at all-ones instead of wrapping back to zero.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, next-PC selection, synchronous imem addressing
// and the IF/ID pipeline register with stall and flush handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               PC_W      = 32,
    parameter int               INSTR_W   = 32,
    parameter logic [PC_W-1:0]  RESET_PC  = PC_W'(0),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_ENCODING),
    parameter int               CNT_W     = 32
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               enable,
    input  logic               PC_write_enable,
    input  logic               IF_ID_pipe_enable,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc_IF_ID,
    output logic [INSTR_W-1:0] instruction_IF_ID,
    output logic               valid_IF_ID,
    output logic               fetch_misaligned,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   stall_count
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    pc_next;
    logic [PC_W-1:0]    redirect_raw;
    logic [PC_W-1:0]    redirect_pc;
    logic               redirect;
    logic               running;

    logic [PC_W-1:0]    if_id_pc_q;
    logic [PC_W-1:0]    if_id_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q;
    logic [INSTR_W-1:0] if_id_instr_d;
    logic               if_id_valid_q;
    logic               if_id_valid_d;
    logic               misaligned_q;
    logic               misaligned_d;

    logic               fetch_inc;
    logic               stall_inc;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= BOOT;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end
    end

    // Memory must always be addressed with what pc_q will hold next, so that
    // imem_rdata lines up with pc_q; frozen cycles re-read the current PC.
    always_comb begin
        running   = (state_q == RUN);
        imem_addr = pc_q;
        if (enable) begin
            imem_addr = running ? pc_next : RESET_PC;
        end
    end

    always_comb begin
        redirect     = jump | branch_taken;
        redirect_raw = jump ? jump_target : branch_target;
        redirect_pc  = {redirect_raw[PC_W-1:2], 2'b00};
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (!PC_write_enable) begin
            pc_next = pc_q;
        end else begin
            pc_next = pc_q + PC_W'(PC_INC);
        end
        // BOOT is fetching RESET_PC, so the PC must stay there for its data to match.
        pc_d = running ? pc_next : RESET_PC;
    end

    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (redirect) begin
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (IF_ID_pipe_enable) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = running;
        end
        misaligned_d = misaligned_q | (redirect && (redirect_raw[1:0] != 2'b00));
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
        end else if (enable) begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign fetch_inc = enable && !redirect && IF_ID_pipe_enable && running;
    assign stall_inc = enable && !redirect && !PC_write_enable;

    sat_counter #(.CNT_W(CNT_W)) u_fetch_counter (
        .clk   (clk),
        .arst  (arst),
        .inc   (fetch_inc),
        .count (fetch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_counter (
        .clk   (clk),
        .arst  (arst),
        .inc   (stall_inc),
        .count (stall_count)
    );

    assign pc_IF_ID          = if_id_pc_q;
    assign instruction_IF_ID = if_id_instr_q;
    assign valid_IF_ID       = if_id_valid_q;
    assign fetch_misaligned  = misaligned_q;

endmodule
